// File: rtl/pipe_ctrl_pkg.sv
// Shared definitions for the pipeline sequencing controller:
// state encoding, PC increment and default widths.
package pipe_ctrl_pkg;

  localparam int unsigned XLEN_DEF  = 32;
  localparam int unsigned RA_W_DEF  = 5;
  localparam int unsigned CNT_W_DEF = 32;

  // Sequential fetch advances by one 32-bit instruction.
  localparam int unsigned PC_INC = 4;

  // Controller states (plain constants so older blocks can share them).
  localparam int unsigned STATE_W = 2;
  localparam logic [1:0] ST_BOOT = 2'd0;
  localparam logic [1:0] ST_RUN  = 2'd1;
  localparam logic [1:0] ST_WAIT = 2'd2;

  // Pipeline-register control bundle produced each cycle.
  typedef struct packed {
    logic pc_stall;
    logic ifid_stall;
    logic ifid_flush;
    logic idex_flush;
  } ctrl_t;

  localparam ctrl_t CTRL_IDLE = '{pc_stall: 1'b0, ifid_stall: 1'b0,
                                  ifid_flush: 1'b0, idex_flush: 1'b0};

endpackage

// File: rtl/pipe_ctrl_hazard_detect.sv
// Load-use hazard detector: the instruction in ID needs a register that the
// load currently in EX has not produced yet. Register x0 never hazards.
module pipe_ctrl_hazard_detect
  import pipe_ctrl_pkg::*;
#(
  parameter int unsigned RA_W = RA_W_DEF
) (
  input  logic [RA_W-1:0] id_rs1_i,
  input  logic            id_rs1_used_i,
  input  logic [RA_W-1:0] id_rs2_i,
  input  logic            id_rs2_used_i,
  input  logic [RA_W-1:0] ex_rd_i,
  input  logic            ex_is_load_i,
  output logic            lu_o
);

  logic rd_nonzero_s;
  logic rs1_hit_s;
  logic rs2_hit_s;

  // Compare both ID sources against the EX load destination.
  always_comb begin
    rd_nonzero_s = (ex_rd_i != {RA_W{1'b0}});
    rs1_hit_s    = id_rs1_used_i & (id_rs1_i == ex_rd_i);
    rs2_hit_s    = id_rs2_used_i & (id_rs2_i == ex_rd_i);
    lu_o         = ex_is_load_i & rd_nonzero_s & (rs1_hit_s | rs2_hit_s);
  end

endmodule

// File: rtl/pipe_ctrl.sv
// Fetch/pipeline sequencing controller for the 5-stage CPU.
// Chooses the next PC and generates stall/flush for PC, IF/ID and ID/EX.
// Priority: redirect > instruction-memory wait > load-use > sequential.
// A redirect that arrives while fetch is waiting is parked and applied when
// the fetch completes. Stall/flush event counters feed trace/debug.
module pipe_ctrl
  import pipe_ctrl_pkg::*;
#(
  parameter int unsigned XLEN  = XLEN_DEF,
  parameter int unsigned RA_W  = RA_W_DEF,
  parameter int unsigned CNT_W = CNT_W_DEF
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [XLEN-1:0]  pc,
  input  logic             imem_ready,
  input  logic [RA_W-1:0]  id_rs1,
  input  logic             id_rs1_used,
  input  logic [RA_W-1:0]  id_rs2,
  input  logic             id_rs2_used,
  input  logic [RA_W-1:0]  ex_rd,
  input  logic             ex_is_load,
  input  logic             ex_redirect,
  input  logic [XLEN-1:0]  ex_target,
  output logic [XLEN-1:0]  npc,
  output logic             pc_stall,
  output logic             ifid_stall,
  output logic             ifid_flush,
  output logic             idex_flush,
  output logic [CNT_W-1:0] stall_cnt,
  output logic [CNT_W-1:0] flush_cnt
);

  // Instruction addresses are word aligned; low two bits always cleared.
  localparam logic [XLEN-1:0] ALIGN_MASK = {{(XLEN-2){1'b1}}, 2'b00};

  logic [STATE_W-1:0] state_q;
  logic [STATE_W-1:0] state_d;
  logic               pend_vld_q;
  logic               pend_vld_d;
  logic [XLEN-1:0]    pend_tgt_q;
  logic [XLEN-1:0]    pend_tgt_d;
  logic [CNT_W-1:0]   stall_cnt_q;
  logic [CNT_W-1:0]   flush_cnt_q;

  logic               lu_s;
  logic [XLEN-1:0]    seq_pc_s;
  logic [XLEN-1:0]    ex_tgt_s;
  logic [XLEN-1:0]    npc_s;
  logic               apply_s;
  ctrl_t              ctrl_s;

  pipe_ctrl_hazard_detect #(
    .RA_W (RA_W)
  ) u_hazard (
    .id_rs1_i      (id_rs1),
    .id_rs1_used_i (id_rs1_used),
    .id_rs2_i      (id_rs2),
    .id_rs2_used_i (id_rs2_used),
    .ex_rd_i       (ex_rd),
    .ex_is_load_i  (ex_is_load),
    .lu_o          (lu_s)
  );

  // Candidate next-PC values, both forced to word alignment.
  always_comb begin
    seq_pc_s = (pc + XLEN'(PC_INC)) & ALIGN_MASK;
    ex_tgt_s = ex_target & ALIGN_MASK;
  end

  // Next-state and control decode by priority.
  always_comb begin
    state_d    = state_q;
    pend_vld_d = pend_vld_q;
    pend_tgt_d = pend_tgt_q;
    npc_s      = seq_pc_s;
    apply_s    = 1'b0;
    ctrl_s     = CTRL_IDLE;
    case (state_q)
      ST_BOOT: begin
        // First cycle out of reset: squash whatever sits in IF/ID.
        ctrl_s.ifid_flush = 1'b1;
        state_d           = ST_RUN;
      end
      ST_RUN, ST_WAIT: begin
        if (ex_redirect && imem_ready) begin
          // Fresh redirect applied immediately; it supersedes any pending one.
          npc_s             = ex_tgt_s;
          ctrl_s.ifid_flush = 1'b1;
          ctrl_s.idex_flush = 1'b1;
          apply_s           = 1'b1;
          pend_vld_d        = 1'b0;
          state_d           = ST_RUN;
        end else if (ex_redirect) begin
          // Fetch still busy: park the target, kill wrong-path work now.
          pend_vld_d        = 1'b1;
          pend_tgt_d        = ex_tgt_s;
          ctrl_s.pc_stall   = 1'b1;
          ctrl_s.ifid_flush = 1'b1;
          ctrl_s.idex_flush = 1'b1;
          state_d           = ST_WAIT;
        end else if (pend_vld_q && imem_ready) begin
          // Fetch completed; now steer to the parked target.
          npc_s             = pend_tgt_q;
          ctrl_s.ifid_flush = 1'b1;
          ctrl_s.idex_flush = 1'b1;
          apply_s           = 1'b1;
          pend_vld_d        = 1'b0;
          state_d           = ST_RUN;
        end else if (!imem_ready) begin
          // Fetch bubble; a load-use in ID still must not advance into EX.
          ctrl_s.pc_stall   = 1'b1;
          ctrl_s.ifid_flush = 1'b1;
          ctrl_s.idex_flush = lu_s;
          state_d           = ST_WAIT;
        end else if (lu_s) begin
          // Hold IF and ID for one cycle, inject a bubble into EX.
          ctrl_s.pc_stall   = 1'b1;
          ctrl_s.ifid_stall = 1'b1;
          ctrl_s.idex_flush = 1'b1;
          state_d           = ST_RUN;
        end else begin
          state_d = ST_RUN;
        end
      end
      default: begin
        // Unreachable encoding: recover through BOOT.
        ctrl_s.ifid_flush = 1'b1;
        pend_vld_d        = 1'b0;
        state_d           = ST_BOOT;
      end
    endcase
  end

  // Drive outputs; a flush always overrides a stall of the same register.
  always_comb begin
    npc        = npc_s;
    pc_stall   = ctrl_s.pc_stall;
    ifid_flush = ctrl_s.ifid_flush;
    ifid_stall = ctrl_s.ifid_stall & ~ctrl_s.ifid_flush;
    idex_flush = ctrl_s.idex_flush;
    stall_cnt  = stall_cnt_q;
    flush_cnt  = flush_cnt_q;
  end

  // State and pending-redirect registers; reset drops any parked redirect.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q    <= ST_BOOT;
      pend_vld_q <= 1'b0;
      pend_tgt_q <= {XLEN{1'b0}};
    end else begin
      state_q    <= state_d;
      pend_vld_q <= pend_vld_d;
      pend_tgt_q <= pend_tgt_d;
    end
  end

  // Debug event counters, free-running with wraparound.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      stall_cnt_q <= {CNT_W{1'b0}};
      flush_cnt_q <= {CNT_W{1'b0}};
    end else begin
      stall_cnt_q <= stall_cnt_q + CNT_W'(ctrl_s.pc_stall);
      flush_cnt_q <= flush_cnt_q + CNT_W'(apply_s);
    end
  end

endmodule
